alu_stage_pipe: RTL

Parametrised, two-stage pipelined successor of the 4-bit dual-lane ALU stage. Each lane computes pre-add/sub and then multiply; a post add/sub combines the two lanes into one result. Sits between op decode/tx and rx, using valid/ready handshakes on both sides. Sustains one command per cycle with a fixed 2-cycle latency and full backpressure.

---
 rtl/alu_stage_pipe_if.sv | 61 ++++++
 rtl/alu_stage_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage_pipe_if.sv
// Control-word package and command/result bus for alu_stage_pipe.
// Defining ALU_STAGE_PIPE_ACC_EN adds acc_mode/acc_clr to the command side.
package alu_pkg;

  localparam int CTRL_SEL_W = 3;

  typedef struct packed {
    logic                  pre_x_en;
    logic                  pre_x_sub;
    logic                  pre_y_en;
    logic                  pre_y_sub;
    logic [CTRL_SEL_W-1:0] mul_x_sel;
    logic [CTRL_SEL_W-1:0] mul_y_sel;
    logic                  mul_x_en;
    logic                  mul_y_en;
    logic                  post_en;
    logic                  post_sub;
  } alu_ctrl_t;

endpackage

interface alu_stage_pipe_if #(
  parameter int W = 4
);
  logic [W-1:0]       x0;
  logic [W-1:0]       x1;
  logic [W-1:0]       y0;
  logic [W-1:0]       y1;
  alu_pkg::alu_ctrl_t ctrl;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               res_valid;
  logic               res_ready;
  logic [2*W+1:0]     res_q;
  logic               carry_q;
`ifdef ALU_STAGE_PIPE_ACC_EN
  logic               acc_mode;
  logic               acc_clr;

  modport master (
    output x0, x1, y0, y1, ctrl, cmd_valid, acc_mode, acc_clr, res_ready,
    input  cmd_ready, res_valid, res_q, carry_q
  );

  modport slave (
    input  x0, x1, y0, y1, ctrl, cmd_valid, acc_mode, acc_clr, res_ready,
    output cmd_ready, res_valid, res_q, carry_q
  );
`else
  modport master (
    output x0, x1, y0, y1, ctrl, cmd_valid, res_ready,
    input  cmd_ready, res_valid, res_q, carry_q
  );

  modport slave (
    input  x0, x1, y0, y1, ctrl, cmd_valid, res_ready,
    output cmd_ready, res_valid, res_q, carry_q
  );
`endif

endinterface

// File: rtl/alu_stage_pipe.sv
// Two-stage dual-lane pre-add/multiply/post-add ALU with valid/ready on both sides.
// Optional accumulator enabled by defining ALU_STAGE_PIPE_ACC_EN.
module alu_stage_pipe #(
  parameter int W     = 4,
  parameter int SEL_W = alu_pkg::CTRL_SEL_W
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_stage_pipe_if.slave bus
);

  localparam int PW = W + 1;
  localparam int RW = 2 * W + 2;

  // Lane 0 is the x lane, lane 1 the y lane.
  logic [1:0][W-1:0]     lane_in0;
  logic [1:0][W-1:0]     lane_in1;
  logic [1:0]            lane_pre_en;
  logic [1:0]            lane_pre_sub;
  logic [1:0]            lane_mul_en;
  logic [1:0][SEL_W-1:0] lane_sel;
  logic [1:0][RW-1:0]    lane_prod;

  assign lane_in0[0]     = bus.x0;
  assign lane_in1[0]     = bus.x1;
  assign lane_in0[1]     = bus.y0;
  assign lane_in1[1]     = bus.y1;
  assign lane_pre_en[0]  = bus.ctrl.pre_x_en;
  assign lane_pre_en[1]  = bus.ctrl.pre_y_en;
  assign lane_pre_sub[0] = bus.ctrl.pre_x_sub;
  assign lane_pre_sub[1] = bus.ctrl.pre_y_sub;
  assign lane_mul_en[0]  = bus.ctrl.mul_x_en;
  assign lane_mul_en[1]  = bus.ctrl.mul_y_en;
  assign lane_sel[0]     = bus.ctrl.mul_x_sel;
  assign lane_sel[1]     = bus.ctrl.mul_y_sel;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [PW-1:0] op_a;
    logic [PW-1:0] op_b;
    logic [PW-1:0] op_other;
    logic [PW-1:0] pre;
    logic [PW-1:0] m1;

    assign op_a     = {1'b0, lane_in0[gi]};
    assign op_b     = {1'b0, lane_in1[gi]};
    assign op_other = {1'b0, lane_in1[1-gi]};

    always_comb begin
      pre = op_a;
      if (lane_pre_en[gi]) begin
        pre = lane_pre_sub[gi] ? (op_a - op_b) : (op_a + op_b);
      end
    end

    always_comb begin
      m1 = '0;
      case (int'(lane_sel[gi]))
        0:       m1 = op_a;
        1:       m1 = op_b;
        2:       m1 = pre;
        3:       m1 = op_other;
        4:       m1 = PW'(1);
        default: m1 = '0;
      endcase
    end

    // With the multiplier bypassed both operands are passed through side by side.
    assign lane_prod[gi] = lane_mul_en[gi] ? (RW'(pre) * RW'(m1)) : {pre, m1};
  end

  logic          fire;
  logic          capture;
  logic          s2_ready;
  logic          cmd_ready;

  logic          s1_valid_q;
  logic          s1_valid_d;
  logic [RW-1:0] x_prod_q;
  logic [RW-1:0] x_prod_d;
  logic [RW-1:0] y_prod_q;
  logic [RW-1:0] y_prod_d;
  logic          s1_post_en_q;
  logic          s1_post_en_d;
  logic          s1_post_sub_q;
  logic          s1_post_sub_d;

  logic          res_valid_q;
  logic          res_valid_d;
  logic [RW-1:0] res_q;
  logic [RW-1:0] res_d;
  logic          carry_q;
  logic          carry_d;

  assign s2_ready  = ~res_valid_q | bus.res_ready;
  assign cmd_ready = ~s1_valid_q | s2_ready;
  assign fire      = bus.cmd_valid & cmd_ready;
  assign capture   = s1_valid_q & s2_ready;

  logic [RW:0]   post_full;
  logic [RW-1:0] post_res;
  logic          post_carry;

  always_comb begin
    if (!s1_post_en_q) begin
      post_full = {1'b0, x_prod_q[W:0], y_prod_q[W:0]};
    end else if (s1_post_sub_q) begin
      post_full = {1'b0, x_prod_q} - {1'b0, y_prod_q};
    end else begin
      post_full = {1'b0, x_prod_q} + {1'b0, y_prod_q};
    end
  end

  assign post_res   = post_full[RW-1:0];
  assign post_carry = post_full[RW];

  logic [RW-1:0] stage_res;
  logic          stage_carry;

`ifdef ALU_STAGE_PIPE_ACC_EN
  logic          s1_acc_mode_q;
  logic          s1_acc_mode_d;
  logic [RW-1:0] acc_q;
  logic [RW-1:0] acc_d;
  logic [RW-1:0] acc_base;
  logic [RW:0]   acc_sum;
  logic          acc_use;

  // A clear in the capture cycle makes that capture start from zero.
  assign acc_base = bus.acc_clr ? '0 : acc_q;
  assign acc_sum  = {1'b0, acc_base} + {1'b0, post_res};
  assign acc_use  = s1_acc_mode_q & s1_post_en_q;

  always_comb begin
    stage_res   = post_res;
    stage_carry = post_carry;
    acc_d       = acc_q;
    if (acc_use) begin
      stage_res   = acc_sum[RW-1:0];
      stage_carry = acc_sum[RW];
    end
    if (capture && acc_use) begin
      acc_d = acc_sum[RW-1:0];
    end else if (bus.acc_clr) begin
      acc_d = '0;
    end
  end

  assign s1_acc_mode_d = fire ? bus.acc_mode : s1_acc_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      s1_acc_mode_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      s1_acc_mode_q <= s1_acc_mode_d;
    end
  end
`else
  assign stage_res   = post_res;
  assign stage_carry = post_carry;
`endif

  // A fire and a capture in the same cycle reload s1 while stage 2 takes the old entry.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    x_prod_d      = x_prod_q;
    y_prod_d      = y_prod_q;
    s1_post_en_d  = s1_post_en_q;
    s1_post_sub_d = s1_post_sub_q;
    if (fire) begin
      s1_valid_d    = 1'b1;
      x_prod_d      = lane_prod[0];
      y_prod_d      = lane_prod[1];
      s1_post_en_d  = bus.ctrl.post_en;
      s1_post_sub_d = bus.ctrl.post_sub;
    end else if (capture) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    carry_d     = carry_q;
    if (capture) begin
      res_valid_d = 1'b1;
      res_d       = stage_res;
      carry_d     = stage_carry;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      x_prod_q      <= '0;
      y_prod_q      <= '0;
      s1_post_en_q  <= 1'b0;
      s1_post_sub_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_q         <= '0;
      carry_q       <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      x_prod_q      <= x_prod_d;
      y_prod_q      <= y_prod_d;
      s1_post_en_q  <= s1_post_en_d;
      s1_post_sub_q <= s1_post_sub_d;
      res_valid_q   <= res_valid_d;
      res_q         <= res_d;
      carry_q       <= carry_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_q     = res_q;
  assign bus.carry_q   = carry_q;

endmodule
